// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with per-frame input snapshot,
// leading-zero blanking, per-digit blink and runtime segment/anode polarity.

package digito_pkg;
  typedef struct packed {
    logic [3:0] digito;
    logic       dp;
  } BCDnumber_t;
endpackage

module sseg_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  digito_pkg::BCDnumber_t digits [N_DIGITS],
  input  logic [N_DIGITS-1:0]    blink_mask,
  input  logic                   blank_lz,
  input  logic                   active_high,
  input  logic                   an_active_high,
  output logic [7:0]             sseg,
  output logic [N_DIGITS-1:0]    an,
  output logic                   frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]          presc;
  logic [IW-1:0]          idx, idx_nxt;
  logic [FW-1:0]          fcnt, fcnt_nxt;
  logic                   phase_on, phase_nxt;
  logic                   running, running_nxt;
  logic                   step, frame;
  digito_pkg::BCDnumber_t snap     [N_DIGITS];
  digito_pkg::BCDnumber_t snap_nxt [N_DIGITS];
  digito_pkg::BCDnumber_t cur;
  logic [N_DIGITS-1:0]    lz_mask;
  logic [N_DIGITS-1:0]    an_code;
  logic [7:0]             code;

  function automatic logic [6:0] seg_lut(input logic [3:0] v);
    case (v)
      4'h0: seg_lut = 7'h3F;
      4'h1: seg_lut = 7'h06;
      4'h2: seg_lut = 7'h5B;
      4'h3: seg_lut = 7'h4F;
      4'h4: seg_lut = 7'h66;
      4'h5: seg_lut = 7'h6D;
      4'h6: seg_lut = 7'h7D;
      4'h7: seg_lut = 7'h07;
      4'h8: seg_lut = 7'h7F;
      4'h9: seg_lut = 7'h67;
      4'hA: seg_lut = 7'h77;
      4'hB: seg_lut = 7'h7C;
      4'hC: seg_lut = 7'h39;
      4'hD: seg_lut = 7'h5E;
      4'hE: seg_lut = 7'h79;
      default: seg_lut = 7'h71;
    endcase
  endfunction

  assign step        = (presc == PW'(REFRESH_DIV - 1));
  assign running_nxt = running | step;

  // The first step after reset lands on position 0 instead of advancing.
  always_comb begin
    idx_nxt = idx;
    if (step) begin
      if (!running || idx == IW'(N_DIGITS - 1)) idx_nxt = '0;
      else                                      idx_nxt = idx + IW'(1);
    end
    frame = step && (idx_nxt == '0);
  end

  // Next-state snapshot and blink phase, so position 0 sees the new frame.
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) snap_nxt[i] = frame ? digits[i] : snap[i];
    fcnt_nxt  = fcnt;
    phase_nxt = phase_on;
    if (frame) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt_nxt  = '0;
        phase_nxt = ~phase_on;
      end else begin
        fcnt_nxt = fcnt + FW'(1);
      end
    end
  end

  always_comb begin
    logic above_zero;
    above_zero = 1'b1;
    lz_mask    = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (i > 0 && above_zero && snap_nxt[i].digito == 4'd0) lz_mask[i] = 1'b1;
      above_zero = above_zero & (snap_nxt[i].digito == 4'd0);
    end
  end

  // Blink wins over blanking; nothing is lit until the first step after reset.
  always_comb begin
    cur  = snap_nxt[idx_nxt];
    code = {cur.dp, seg_lut(cur.digito)};
    if (blank_lz && lz_mask[idx_nxt])        code[6:0] = '0;
    if (!phase_nxt && blink_mask[idx_nxt])   code      = '0;
    if (!running_nxt)                        code      = '0;
    an_code = running_nxt ? (N_DIGITS'(1) << idx_nxt) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      idx        <= '0;
      running    <= 1'b0;
      fcnt       <= '0;
      phase_on   <= 1'b1;
      for (int i = 0; i < N_DIGITS; i++) snap[i] <= '0;
      frame_tick <= 1'b0;
      an         <= an_active_high ? '0 : '1;
      sseg       <= active_high ? 8'h00 : 8'hFF;
    end else begin
      presc      <= step ? '0 : presc + PW'(1);
      idx        <= idx_nxt;
      running    <= running_nxt;
      fcnt       <= fcnt_nxt;
      phase_on   <= phase_nxt;
      for (int i = 0; i < N_DIGITS; i++) snap[i] <= snap_nxt[i];
      frame_tick <= frame;
      an         <= an_active_high ? an_code : ~an_code;
      sseg       <= active_high ? code : ~code;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed scoreboard bench for sseg_scan_driver: each frame's expected pin
// values are queued when digits are driven and popped at every scan step.

module tb_sseg_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BF = 2;

  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
  } exp_t;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic                   clk = 1'b0;
  logic                   reset;
  digito_pkg::BCDnumber_t digits [N];
  logic [N-1:0]           blink_mask;
  logic                   blank_lz;
  logic                   active_high;
  logic                   an_active_high;
  logic [7:0]             sseg;
  logic [N-1:0]           an;
  logic                   frame_tick;

  exp_t exp_q[$];
  int   n_vectors     = 0;
  int   n_miscompares = 0;
  int   frame_k       = 0;

  sseg_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk            (clk),
    .reset          (reset),
    .digits         (digits),
    .blink_mask     (blink_mask),
    .blank_lz       (blank_lz),
    .active_high    (active_high),
    .an_active_high (an_active_high),
    .sseg           (sseg),
    .an             (an),
    .frame_tick     (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vectors++;
    assert (obs === exp) else begin
      n_miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0, input logic [3:0] dps);
    digits[3] = '{digito: d3, dp: dps[3]};
    digits[2] = '{digito: d2, dp: dps[2]};
    digits[1] = '{digito: d1, dp: dps[1]};
    digits[0] = '{digito: d0, dp: dps[0]};
  endtask

  // Queue one frame of expectations from the inputs that the next frame edge latches.
  task automatic applyStimulus();
    exp_t e;
    logic [7:0] c;
    logic [3:0] a;
    logic phase_on;
    logic zero_above;
    frame_k++;
    phase_on = ((frame_k / BF) % 2) == 0;
    for (int p = 0; p < N; p++) begin
      c = {digits[p].dp, SEG_TAB[digits[p].digito]};
      if (blank_lz && p > 0) begin
        zero_above = 1'b1;
        for (int j = p; j < N; j++) if (digits[j].digito != 4'd0) zero_above = 1'b0;
        if (zero_above) c[6:0] = '0;
      end
      if (!phase_on && blink_mask[p]) c = 8'h00;
      if (!active_high) c = ~c;
      a = 4'b0001 << p;
      if (!an_active_high) a = ~a;
      e.an   = a;
      e.sseg = c;
      exp_q.push_back(e);
    end
  endtask

  task automatic checkOutput(input int pos, input int cycles);
    exp_t e;
    repeat (cycles) @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vectors++;
      n_miscompares++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      check8($sformatf("an_f%0d_p%0d", frame_k, pos), {4'h0, an}, {4'h0, e.an});
      check8($sformatf("sseg_f%0d_p%0d", frame_k, pos), sseg, e.sseg);
    end
    if (pos == 0) check8($sformatf("tick_f%0d", frame_k), {7'h0, frame_tick}, 8'h01);
    if (pos == 1) check8($sformatf("notick_f%0d", frame_k), {7'h0, frame_tick}, 8'h00);
  endtask

  task automatic run_frame();
    applyStimulus();
    for (int p = 0; p < N; p++) checkOutput(p, RD);
  endtask

  initial begin
    reset          = 1'b1;
    blink_mask     = '0;
    blank_lz       = 1'b0;
    active_high    = 1'b1;
    an_active_high = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);

    repeat (3) @(posedge clk);
    #1;
    check8("reset_sseg", sseg, 8'h00);
    check8("reset_an", {4'h0, an}, 8'h0F);
    check8("reset_tick", {7'h0, frame_tick}, 8'h00);

    reset = 1'b0;
    set_digits(4'd3, 4'd2, 4'd1, 4'd0, 4'b0100);
    applyStimulus();
    repeat (3) @(posedge clk);
    #1;
    check8("pre_step_an", {4'h0, an}, 8'h0F);
    checkOutput(0, 1);
    for (int p = 1; p < N; p++) checkOutput(p, RD);
    run_frame();

    // Inputs changed after position 1 must not reach this frame.
    applyStimulus();
    checkOutput(0, RD);
    checkOutput(1, RD);
    set_digits(4'hD, 4'hC, 4'hB, 4'hA, 4'b0000);
    checkOutput(2, RD);
    checkOutput(3, RD);
    run_frame();

    blank_lz = 1'b1;
    set_digits(4'd0, 4'd0, 4'd7, 4'd0, 4'b0000);
    run_frame();
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
    run_frame();
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b1000);
    run_frame();

    blank_lz   = 1'b0;
    blink_mask = 4'b0001;
    set_digits(4'd3, 4'd2, 4'd1, 4'd8, 4'b0001);
    for (int f = 0; f < 4; f++) run_frame();

    blink_mask = '0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
    applyStimulus();
    checkOutput(0, RD);
    active_high = 1'b0;
    @(posedge clk);
    #1;
    check8("pol_flip_sseg", sseg, 8'hC0);
    check8("pol_flip_tick", {7'h0, frame_tick}, 8'h00);

    reset = 1'b1;
    @(posedge clk);
    #1;
    check8("midreset_an", {4'h0, an}, 8'h0F);
    check8("midreset_sseg", sseg, 8'hFF);
    reset          = 1'b0;
    an_active_high = 1'b1;
    exp_q.delete();
    frame_k = 0;
    set_digits(4'd3, 4'd2, 4'd1, 4'd0, 4'b0100);
    run_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Parametrised time-multiplexed driver for an N-digit common-anode/common-cathode seven-segment display.
- Takes one BCD/hex digit plus decimal point per position (digito_pkg::BCDnumber_t array), snapshots it once per frame and scans digits at a programmable refresh rate.
- Adds per-digit blink, leading-zero blanking, and runtime segment/anode polarity selection.
- Sits between the FSM/counter datapath and the board display pins.

Parameters:
- N_DIGITS, 4, number of display positions (1..8); index 0 = least significant, rightmost.
- REFRESH_DIV, 100000, clk cycles each digit stays lit (>=2).
- BLINK_FRAMES, 64, full frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digits  in  BCDnumber_t [N_DIGITS]  per-position value: .digito 4 bits, .dp 1 bit.
- blink_mask  in  N_DIGITS  1 = position blinks.
- blank_lz  in  1  1 = suppress leading zeros.
- active_high  in  1  segment polarity: 1 = lit segment drives 1.
- an_active_high  in  1  anode polarity: 1 = selected digit drives 1.
- sseg  out  8  {dp,g,f,e,d,c,b,a}, registered.
- an  out  N_DIGITS  one-hot digit select (one-cold if an_active_high=0), registered.
- frame_tick  out  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `reset`; all state changes occur on the rising edge of clk.
- Reset:
  - prescaler=0, scan index idx=0, frame counter=0, blink phase=ON.
  - Snapshot registers = all zeros.
  - frame_tick=0.
  - an = all inactive (0 if an_active_high else all 1s).
  - sseg = all off (8'h00 if active_high else 8'hFF).
  - Reset asserted mid-scan aborts immediately; the first digit after release is position 0, shown REFRESH_DIV cycles after reset deasserts.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - The terminal-count cycle is the "step".
  - Width is $clog2(REFRESH_DIV).
- Scan:
  - On each step edge, idx advances idx+1, wrapping N_DIGITS-1 -> 0.
  - an and sseg are registered from the next idx and update on the same edge.
  - Zero latency between idx change and pins; exactly one anode is active at any time after the first step.
- Frame:
  - On a step edge where idx wraps to 0:
    - digits is copied into the snapshot.
    - The frame counter increments; when it reaches BLINK_FRAMES-1 it clears and the blink phase toggles.
    - frame_tick=1 during the following cycle only.
  - Position 0 of the new frame displays the newly latched value (bypass on that edge).
  - Inputs changing mid-frame never affect the current frame.
- Segment code (gfe_dcba, before dp and polarity):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:67, A:77, B:7C, C:39, D:5E, E:79, F:71
  - dp from snapshot .dp.
- Leading-zero blanking (blank_lz=1):
  - Position i>0 is blanked if its snapshot digito==0 and all positions above i are zero.
  - Position 0 is never blanked.
  - Blanked position: segments a-g off, dp still honoured.
- Blink: when blink phase=OFF and blink_mask[i]=1, position i shows all 8 bits off, dp included. Blink overrides LZ blanking.
- Polarity: sseg = active_high ? code : ~code; an likewise with an_active_high. Both are sampled combinationally into the output registers, so a change takes effect on the next clk edge, not the next step.
- N_DIGITS=1: idx constant 0; a frame occurs on every step.

Test Plan:
- N_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2. Reset 3 cycles, active_high=1, an_active_high=0 -> during reset sseg=8'h00, an=4'hF; 4 cycles after release an=4'b1110, sseg=8'h3F (snapshot zeros).
- digits={3,2,1,0} with dp only on position 2, held 2 frames -> per step sseg sequence 3F,06,DB,4F; an 1110,1101,1011,0111; frame_tick pulses every 16 cycles.
- Change digits mid-frame (after position 1 shown) -> positions 2,3 still show the old values; new values appear only after the next frame_tick.
- blank_lz=1, digits={0,0,7,0} -> positions 3,2 show 8'h00, position 1 shows 07, position 0 shows 3F; all-zero input -> only position 0 lit (3F).
- blink_mask=4'b0001, digits position 0=8 with dp=1 -> position 0 alternates FF (2 frames) / 00 (2 frames); other positions unaffected.
- Toggle active_high=0 mid-digit -> sseg inverts on the next edge (e.g. 3F->C0); assert reset mid-frame -> next cycle an inactive and idx restarts at 0.
